// File: rtl/mcs4_cycle_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mcs4_cycle_seq_if
// Purpose  : Bus and handshake bundle for the MCS-4 style instruction-cycle
//            sequencer. The sequencer sits on the slave side; the
//            ROM/RAM/decoder environment drives it from the master side.
// Revision : 1.0 - initial release
// ============================================================================
interface mcs4_cycle_seq_if;
    logic        stall;
    logic [3:0]  dbus_in;
    logic [3:0]  dbus_out;
    logic        dbus_oe;
    logic        clken_1;
    logic        clken_2;
    logic        sync;
    logic [2:0]  icyc;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        instr_valid;
    logic [1:0]  pc_op;
    logic        pc_op_valid;
    logic [11:0] jump_addr;
    logic [11:0] pc;
    logic        stack_ovf;
    logic        stack_udf;

    modport master (
        output stall, dbus_in, pc_op, pc_op_valid, jump_addr,
        input  dbus_out, dbus_oe, clken_1, clken_2, sync, icyc,
               opr, opa, instr_valid, pc, stack_ovf, stack_udf
    );

    modport slave (
        input  stall, dbus_in, pc_op, pc_op_valid, jump_addr,
        output dbus_out, dbus_oe, clken_1, clken_2, sync, icyc,
               opr, opa, instr_valid, pc, stack_ovf, stack_udf
    );
endinterface
`default_nettype wire

// File: rtl/mcs4_cycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : mcs4_cycle_seq
// Purpose  : Eight-subcycle instruction sequencer (A1..X3) with phase enables,
//            nibble-serial PC output, opcode capture and a circular
//            return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module mcs4_cycle_seq #(
    parameter int PHASE_CLKS  = 2,
    parameter int STACK_DEPTH = 3
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mcs4_cycle_seq_if.slave bus
);
    localparam int CYC_CLKS = 2 * PHASE_CLKS;
    localparam int CNT_W    = (CYC_CLKS > 1) ? $clog2(CYC_CLKS) : 1;
    localparam int SP_W     = $clog2(STACK_DEPTH);
    localparam int OCC_W    = $clog2(STACK_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYC_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_PH2  = CNT_W'(PHASE_CLKS);
    localparam logic [SP_W-1:0]  SP_MAX   = SP_W'(STACK_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(STACK_DEPTH);

    localparam logic [2:0] CY_A1 = 3'd0;
    localparam logic [2:0] CY_A2 = 3'd1;
    localparam logic [2:0] CY_A3 = 3'd2;
    localparam logic [2:0] CY_M1 = 3'd3;
    localparam logic [2:0] CY_M2 = 3'd4;
    localparam logic [2:0] CY_X1 = 3'd5;
    localparam logic [2:0] CY_X2 = 3'd6;
    localparam logic [2:0] CY_X3 = 3'd7;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       icyc_q, icyc_d;
    logic [0:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [11:0]      addr_q, addr_d;
    logic [11:0]      pc_q, pc_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [3:0]       opr_q, opa_q;
    logic [11:0]      stack_q [STACK_DEPTH];

    logic             w_run;
    logic             w_end_x3;
    logic             w_clken_2;
    logic             w_take;
    logic [1:0]       w_op;
    logic [11:0]      w_addr;
    logic [11:0]      w_pc_inc;
    logic [SP_W-1:0]  w_sp_inc;
    logic [SP_W-1:0]  w_sp_dec;
    logic             w_push;
    logic [3:0]       w_dbus;

    assign w_run     = (state_q == ST_RUN);
    assign w_end_x3  = w_run && (icyc_q == CY_X3) && (cnt_q == CNT_LAST);
    assign w_clken_2 = w_run && (cnt_q == CNT_PH2);
    // A request on the update clock itself still counts (last sample wins).
    assign w_take    = w_run && bus.pc_op_valid &&
                       ((icyc_q == CY_X1) || (icyc_q == CY_X2) || (icyc_q == CY_X3));
    assign w_op      = w_take ? bus.pc_op : op_q;
    assign w_addr    = w_take ? bus.jump_addr : addr_q;
    assign w_pc_inc  = pc_q + 12'd1;
    assign w_sp_inc  = (sp_q == SP_MAX) ? '0 : sp_q + SP_W'(1);
    assign w_sp_dec  = (sp_q == '0) ? SP_MAX : sp_q - SP_W'(1);

    // Phase counter / subcycle advance, with the X3 hold and its release to A1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        icyc_d  = icyc_q;
        if (state_q == ST_HOLD) begin
            if (!bus.stall) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                icyc_d  = CY_A1;
            end
        end else if (cnt_q == CNT_LAST) begin
            if ((icyc_q == CY_X3) && bus.stall) begin
                state_d = ST_HOLD;
            end else begin
                cnt_d  = '0;
                icyc_d = icyc_q + 3'd1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pending PC operation: cleared at every update and ignored while held.
    always_comb begin
        op_d   = op_q;
        addr_d = addr_q;
        if (w_end_x3 || !w_run) begin
            op_d = OP_INC;
        end else if (w_take) begin
            op_d   = bus.pc_op;
            addr_d = bus.jump_addr;
        end
    end

    // PC and stack-pointer update at the last clock of X3.
    always_comb begin
        pc_d   = pc_q;
        sp_d   = sp_q;
        occ_d  = occ_q;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        w_push = 1'b0;
        if (w_end_x3) begin
            case (w_op)
                OP_INC: pc_d = w_pc_inc;
                OP_JMP: pc_d = w_addr;
                OP_CALL: begin
                    w_push = 1'b1;
                    pc_d   = w_addr;
                    sp_d   = w_sp_inc;
                    if (occ_q == OCC_FULL) ovf_d = 1'b1;
                    else                   occ_d = occ_q + OCC_W'(1);
                end
                OP_RET: begin
                    pc_d = stack_q[w_sp_dec];
                    sp_d = w_sp_dec;
                    if (occ_q == '0) udf_d = 1'b1;
                    else             occ_d = occ_q - OCC_W'(1);
                end
            endcase
        end
    end

    // Sequencer, op latch, PC and error-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            icyc_q  <= CY_A1;
            op_q    <= OP_INC;
            addr_q  <= '0;
            pc_q    <= '0;
            sp_q    <= '0;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            icyc_q  <= icyc_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            occ_q   <= occ_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Return-address storage; a push into a full stack overwrites the oldest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else if (w_push) begin
            stack_q[sp_q] <= w_pc_inc;
        end
    end

    // Opcode nibble capture on the phase-2 enable of M1 and M2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opr_q <= '0;
            opa_q <= '0;
        end else begin
            if (w_clken_2 && (icyc_q == CY_M1)) opr_q <= bus.dbus_in;
            if (w_clken_2 && (icyc_q == CY_M2)) opa_q <= bus.dbus_in;
        end
    end

    // PC nibble sent out during A1..A3, bus released otherwise.
    always_comb begin
        case (icyc_q)
            CY_A1:   w_dbus = pc_q[3:0];
            CY_A2:   w_dbus = pc_q[7:4];
            CY_A3:   w_dbus = pc_q[11:8];
            default: w_dbus = 4'h0;
        endcase
    end

    assign bus.dbus_out    = w_dbus;
    assign bus.dbus_oe     = (icyc_q == CY_A1) || (icyc_q == CY_A2) || (icyc_q == CY_A3);
    assign bus.clken_1     = w_run && (cnt_q == '0);
    assign bus.clken_2     = w_clken_2;
    assign bus.sync        = (icyc_q == CY_X3);
    assign bus.icyc        = icyc_q;
    assign bus.opr         = opr_q;
    assign bus.opa         = opa_q;
    assign bus.instr_valid = w_run && (icyc_q == CY_M2) && (cnt_q == CNT_LAST);
    assign bus.pc          = pc_q;
    assign bus.stack_ovf   = ovf_q;
    assign bus.stack_udf   = udf_q;
endmodule
`default_nettype wire
